// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
//   Bundles every handshake and bus signal around the memory arbiter: the
//   three cache-side requester channels and the single off-chip memory port.
//   Clock and reset stay plain ports on the modules that use this bundle.
//
//   Parameters
//     ADDR_W  line address width
//     DATA_W  line width moved per transaction
//
//   Signals
//     Icache line read   : ic_read_req/addr  -> ic_read_ack/data
//     Dcache line read   : dc_read_req/addr  -> dc_read_ack/data
//     Dcache write-back  : dc_write_req/addr/data -> dc_write_ack
//     Memory port        : mem_enable/rw/addr/data_out -> mem_ack/data_in
//
//   Modports
//     master : the arbiter's view (drives acks, read lines and memory request)
//     slave  : the environment's view (caches plus memory)
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 128
);

   // Icache line read channel
   logic              ic_read_req;
   logic [ADDR_W-1:0] ic_read_addr;
   logic              ic_read_ack;
   logic [DATA_W-1:0] ic_read_data;

   // Dcache line read channel
   logic              dc_read_req;
   logic [ADDR_W-1:0] dc_read_addr;
   logic              dc_read_ack;
   logic [DATA_W-1:0] dc_read_data;

   // Dcache write-back channel
   logic              dc_write_req;
   logic [ADDR_W-1:0] dc_write_addr;
   logic [DATA_W-1:0] dc_write_data;
   logic              dc_write_ack;

   // Off-chip memory port
   logic              mem_enable;
   logic              mem_rw;
   logic              mem_ack;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data_in;
   logic [DATA_W-1:0] mem_data_out;

   modport master (
      input  ic_read_req,
      input  ic_read_addr,
      output ic_read_ack,
      output ic_read_data,
      input  dc_read_req,
      input  dc_read_addr,
      output dc_read_ack,
      output dc_read_data,
      input  dc_write_req,
      input  dc_write_addr,
      input  dc_write_data,
      output dc_write_ack,
      output mem_enable,
      output mem_rw,
      input  mem_ack,
      output mem_addr,
      input  mem_data_in,
      output mem_data_out
   );

   modport slave (
      output ic_read_req,
      output ic_read_addr,
      input  ic_read_ack,
      input  ic_read_data,
      output dc_read_req,
      output dc_read_addr,
      input  dc_read_ack,
      input  dc_read_data,
      output dc_write_req,
      output dc_write_addr,
      output dc_write_data,
      input  dc_write_ack,
      input  mem_enable,
      input  mem_rw,
      output mem_ack,
      input  mem_addr,
      output mem_data_in,
      input  mem_data_out
   );

endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Shares the single off-chip memory port between the Icache line read, the
//   Dcache line read and the Dcache line write-back. One transaction is in
//   flight at a time; the memory request is held stable until mem_ack, and
//   the winning requester gets a one-cycle ack pulse the cycle after.
//
//   Ports
//     clk    rising-edge clock
//     reset  asynchronous, active-low reset
//     bus    mem_arbiter_if.master : requester channels and memory port
//
//   Timing of one transaction (mem_ack seen at cycle M)
//     IDLE samples requests at cycle G, mem_enable is high from G+1,
//     RESP with the ack pulse and mem_enable low at M+1, IDLE again at M+2,
//     so the next mem_enable can rise at M+3 at the earliest.
//
//   Configuration
//     ARB_ROUND_ROBIN_EN  when defined, a tie between the Dcache read and the
//                         Icache read goes to the port not granted last; the
//                         write-back always keeps top priority. When
//                         undefined the order is fixed:
//                         dc_write > dc_read > ic_read.
// ---------------------------------------------------------------------------
module mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 128
) (
   input  logic          clk,
   input  logic          reset,
   mem_arbiter_if.master bus
);

   typedef enum logic [2:0] {
      IDLE,
      DC_WR,
      DC_RD,
      IC_RD,
      RESP
   } state_t;

   state_t state_q, state_d;

   // Registered memory request; held constant for the whole transaction
   logic              en_q,    en_d;
   logic              rw_q,    rw_d;
   logic [ADDR_W-1:0] addr_q,  addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

   // Registered responses to the requesters
   logic              ic_ack_q,    ic_ack_d;
   logic              dc_rd_ack_q, dc_rd_ack_d;
   logic              dc_wr_ack_q, dc_wr_ack_d;
   logic [DATA_W-1:0] ic_data_q,   ic_data_d;
   logic [DATA_W-1:0] dc_data_q,   dc_data_d;

   // Decides whether the Dcache read beats the Icache read this cycle
   logic dc_rd_wins;

`ifdef ARB_ROUND_ROBIN_EN
   typedef enum logic {
      GNT_DC,
      GNT_IC
   } grant_t;

   grant_t last_grant_q, last_grant_d;

   // On a tie the port that did not win the previous read grant goes first
   always_comb begin
      dc_rd_wins = bus.dc_read_req &
                   (~bus.ic_read_req | (last_grant_q == GNT_IC));
   end
`else
   // Fixed order: a pending Dcache read always beats the Icache read,
   // so a stream of Dcache misses can starve the Icache
   always_comb begin
      dc_rd_wins = bus.dc_read_req;
   end
`endif

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // Next state and next register values
   // ------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      en_d        = en_q;
      rw_d        = rw_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      ic_ack_d    = 1'b0;
      dc_rd_ack_d = 1'b0;
      dc_wr_ack_d = 1'b0;
      ic_data_d   = ic_data_q;
      dc_data_d   = dc_data_q;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_d = last_grant_q;
`endif

      case (state_q)
         IDLE: begin
            // The write-back goes first so a dirty eviction always
            // reaches memory before the refill of the same line
            if (bus.dc_write_req) begin
               state_d = DC_WR;
               en_d    = 1'b1;
               rw_d    = 1'b1;
               addr_d  = bus.dc_write_addr;
               wdata_d = bus.dc_write_data;
            end else if (dc_rd_wins) begin
               state_d = DC_RD;
               en_d    = 1'b1;
               rw_d    = 1'b0;
               addr_d  = bus.dc_read_addr;
`ifdef ARB_ROUND_ROBIN_EN
               last_grant_d = GNT_DC;
`endif
            end else if (bus.ic_read_req) begin
               state_d = IC_RD;
               en_d    = 1'b1;
               rw_d    = 1'b0;
               addr_d  = bus.ic_read_addr;
`ifdef ARB_ROUND_ROBIN_EN
               last_grant_d = GNT_IC;
`endif
            end
         end

         DC_WR: begin
            if (bus.mem_ack) begin
               state_d     = RESP;
               en_d        = 1'b0;
               dc_wr_ack_d = 1'b1;
            end
         end

         DC_RD: begin
            if (bus.mem_ack) begin
               state_d     = RESP;
               en_d        = 1'b0;
               dc_rd_ack_d = 1'b1;
               dc_data_d   = bus.mem_data_in;
            end
         end

         IC_RD: begin
            if (bus.mem_ack) begin
               state_d   = RESP;
               en_d      = 1'b0;
               ic_ack_d  = 1'b1;
               ic_data_d = bus.mem_data_in;
            end
         end

         // One dead cycle lets the requester drop its level request
         // before IDLE samples again
         RESP: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Output and datapath registers; reset aborts any transaction in
   // flight, so mem_enable falls and no ack is produced
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         en_q        <= 1'b0;
         rw_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         ic_ack_q    <= 1'b0;
         dc_rd_ack_q <= 1'b0;
         dc_wr_ack_q <= 1'b0;
         ic_data_q   <= '0;
         dc_data_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         last_grant_q <= GNT_DC;
`endif
      end else begin
         en_q        <= en_d;
         rw_q        <= rw_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         ic_ack_q    <= ic_ack_d;
         dc_rd_ack_q <= dc_rd_ack_d;
         dc_wr_ack_q <= dc_wr_ack_d;
         ic_data_q   <= ic_data_d;
         dc_data_q   <= dc_data_d;
`ifdef ARB_ROUND_ROBIN_EN
         last_grant_q <= last_grant_d;
`endif
      end
   end

   assign bus.mem_enable   = en_q;
   assign bus.mem_rw       = rw_q;
   assign bus.mem_addr     = addr_q;
   assign bus.mem_data_out = wdata_q;
   assign bus.ic_read_ack  = ic_ack_q;
   assign bus.ic_read_data = ic_data_q;
   assign bus.dc_read_ack  = dc_rd_ack_q;
   assign bus.dc_read_data = dc_data_q;
   assign bus.dc_write_ack = dc_wr_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//   Drives three level-request cache requesters and a memory with random
//   latency and stray acks, and compares every cycle against a
//   transaction-level reference: when the bus is free the winner is chosen
//   from the pending requests by the priority rule, the request is expected
//   on the memory port from the next cycle until mem_ack, and the ack plus
//   captured line are expected the cycle after. Directed phases at the start
//   cover the single read, write-before-read, tie handling, dropped request
//   and stray ack cases; one reset is applied mid-transaction.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

   localparam int AW   = 32;
   localparam int DW   = 128;
   localparam int NCYC = 1600;

   localparam int OWN_WR = 0;
   localparam int OWN_DC = 1;
   localparam int OWN_IC = 2;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc;

   // Requester state, index OWN_WR / OWN_DC / OWN_IC
   bit            req   [3];
   bit            outst [3];
   logic [AW-1:0] raddr [3];
   logic [DW-1:0] wr_data;

   // Memory model
   bit m_acked;
   int m_cnt;
   int m_lat;

   // Reset scheduling
   int rel_cyc;
   int quiet_until;
   bit rst_done;

   // Reference model
   bit            mdl_busy;
   int            mdl_own;
   int            mdl_g;
   bit            mdl_rw;
   logic [AW-1:0] mdl_addr;
   logic [DW-1:0] mdl_wdata;
   int            mdl_ack_cyc;
   int            mdl_ack_own;
   int            mdl_samp_from;
   int            mdl_last;
   bit            mdl_fresh;
   logic [DW-1:0] exp_ic;
   logic [DW-1:0] exp_dc;

   int dq[$];
   int tq[$];
   int t5_acks;

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int pick(bit w, bit r, bit i, int last);
      if (w) return OWN_WR;
      if (r && i) begin
`ifdef ARB_ROUND_ROBIN_EN
         return (last == OWN_IC) ? OWN_DC : OWN_IC;
`else
         return OWN_DC;
`endif
      end
      if (r) return OWN_DC;
      return OWN_IC;
   endfunction

   function automatic logic [DW-1:0] rnd_line();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic raise(input int k, input logic [AW-1:0] a);
      req[k]   = 1'b1;
      outst[k] = 1'b1;
      raddr[k] = a;
      if (k == OWN_WR) wr_data = rnd_line();
   endtask

   task automatic apply_inputs();
      bus.dc_write_req  = req[OWN_WR];
      bus.dc_write_addr = raddr[OWN_WR];
      bus.dc_write_data = wr_data;
      bus.dc_read_req   = req[OWN_DC];
      bus.dc_read_addr  = raddr[OWN_DC];
      bus.ic_read_req   = req[OWN_IC];
      bus.ic_read_addr  = raddr[OWN_IC];
   endtask

   // Runs just after the active edge: reacts to the cycle's DUT outputs
   task automatic drive_step();
      bit ackv [3];
      bit just [3];
      if (!reset && cyc == rel_cyc) begin
         reset = 1'b1;
      end else if (reset && !rst_done &&
                   ((cyc > 800 && mdl_busy && mdl_own == OWN_IC && cyc == mdl_g + 3) ||
                    cyc == 1400)) begin
         reset       = 1'b0;
         rst_done    = 1'b1;
         rel_cyc     = cyc + 2;
         quiet_until = cyc + 6;
         #1;
         chk("rst_en_drop", bus.mem_enable, 1'b0);
         chk("rst_no_ack", {bus.ic_read_ack, bus.dc_read_ack, bus.dc_write_ack}, 3'b000);
      end

      ackv[OWN_WR] = bus.dc_write_ack;
      ackv[OWN_DC] = bus.dc_read_ack;
      ackv[OWN_IC] = bus.ic_read_ack;

      if (!reset) begin
         for (int k = 0; k < 3; k++) begin
            req[k]   = 1'b0;
            outst[k] = 1'b0;
         end
         bus.mem_ack = 1'b0;
         m_acked     = 1'b0;
         m_cnt       = 0;
      end else begin
         // Memory: ack once per transaction after a random latency
         if (bus.mem_enable && !m_acked) begin
            if (m_cnt == 0) m_lat = (cyc < 160) ? 3 : $urandom_range(0, 4);
            if (m_cnt == m_lat) begin
               bus.mem_ack = 1'b1;
               m_acked     = 1'b1;
            end else begin
               bus.mem_ack = 1'b0;
            end
            m_cnt++;
         end else begin
            if (!bus.mem_enable) begin
               m_acked = 1'b0;
               m_cnt   = 0;
            end
            if (cyc < 160) bus.mem_ack = (cyc == 50);
            else           bus.mem_ack = ($urandom_range(0, 7) == 0);
         end

         for (int k = 0; k < 3; k++) begin
            just[k] = 1'b0;
            if (ackv[k]) begin
               req[k]   = 1'b0;
               outst[k] = 1'b0;
               just[k]  = 1'b1;
            end
         end

         if (cyc == 5)  raise(OWN_IC, 32'h100);
         if (cyc == 30) begin
            raise(OWN_WR, 32'h200);
            raise(OWN_DC, 32'h200);
         end
         if (cyc == 60) raise(OWN_IC, 32'h300);
         if (cyc == 62) req[OWN_IC] = 1'b0;

         for (int k = 0; k < 3; k++) begin
            if (cyc >= 80 && cyc < 160 && k != OWN_WR && !outst[k] && !just[k])
               raise(k, $urandom & 32'hFFFF_FFF0);
            if (cyc >= 160 && cyc < 1500) begin
               if (outst[k] && req[k] && mdl_busy && mdl_own == k && cyc > mdl_g &&
                   $urandom_range(0, 5) == 0)
                  req[k] = 1'b0;
               if (!outst[k] && !just[k] && cyc >= quiet_until && $urandom_range(0, 2) == 0)
                  raise(k, $urandom & 32'hFFFF_FFF0);
            end
         end
      end

      bus.mem_data_in = (cyc < 80) ? {16{8'hA5}} : rnd_line();
      apply_inputs();
   endtask

   // Runs on the inactive edge: compares the cycle, then advances the model
   task automatic model_step();
      bit exp_en;
      int w;
      if (!reset) begin
         chk("rst_ctl", {bus.mem_enable, bus.mem_rw, bus.ic_read_ack,
                         bus.dc_read_ack, bus.dc_write_ack}, 5'b0);
         chk("rst_addr", bus.mem_addr, '0);
         chk("rst_wdata", bus.mem_data_out, '0);
         chk("rst_ic_data", bus.ic_read_data, '0);
         chk("rst_dc_data", bus.dc_read_data, '0);
         mdl_busy      = 1'b0;
         mdl_ack_cyc   = -1;
         mdl_samp_from = cyc + 1;
         mdl_last      = OWN_DC;
         mdl_fresh     = 1'b1;
         exp_ic        = '0;
         exp_dc        = '0;
         return;
      end

      exp_en = mdl_busy && cyc > mdl_g;
      chk("mem_enable", bus.mem_enable, exp_en);
      chk("dc_write_ack", bus.dc_write_ack, cyc == mdl_ack_cyc && mdl_ack_own == OWN_WR);
      chk("dc_read_ack", bus.dc_read_ack, cyc == mdl_ack_cyc && mdl_ack_own == OWN_DC);
      chk("ic_read_ack", bus.ic_read_ack, cyc == mdl_ack_cyc && mdl_ack_own == OWN_IC);
      chk("ic_read_data", bus.ic_read_data, exp_ic);
      chk("dc_read_data", bus.dc_read_data, exp_dc);
      if (exp_en) begin
         chk("mem_rw", bus.mem_rw, mdl_rw);
         chk("mem_addr", bus.mem_addr, mdl_addr);
         if (mdl_rw) chk("mem_data_out", bus.mem_data_out, mdl_wdata);
      end
      if (mdl_fresh) begin
         chk("idle_addr", bus.mem_addr, '0);
         chk("idle_rw_wdata", {bus.mem_rw, bus.mem_data_out}, '0);
      end

      if (cyc < 20 && bus.mem_enable) chk("t1_addr", bus.mem_addr, 32'h100);
      if (cyc < 30 && bus.ic_read_ack) chk("t1_data", bus.ic_read_data, {16{8'hA5}});
      if (cyc >= 60 && cyc < 80 && bus.ic_read_ack) t5_acks++;

      if (exp_en && bus.mem_ack) begin
         mdl_busy      = 1'b0;
         mdl_ack_cyc   = cyc + 1;
         mdl_ack_own   = mdl_own;
         mdl_samp_from = cyc + 2;
         if (mdl_own == OWN_IC) exp_ic = bus.mem_data_in;
         if (mdl_own == OWN_DC) exp_dc = bus.mem_data_in;
      end else if (!mdl_busy && cyc >= mdl_samp_from &&
                   (bus.dc_write_req || bus.dc_read_req || bus.ic_read_req)) begin
         w         = pick(bus.dc_write_req, bus.dc_read_req, bus.ic_read_req, mdl_last);
         mdl_busy  = 1'b1;
         mdl_own   = w;
         mdl_g     = cyc;
         mdl_fresh = 1'b0;
         mdl_rw    = (w == OWN_WR);
         if (w == OWN_WR) begin
            mdl_addr  = bus.dc_write_addr;
            mdl_wdata = bus.dc_write_data;
         end else if (w == OWN_DC) begin
            mdl_addr = bus.dc_read_addr;
            mdl_last = OWN_DC;
         end else begin
            mdl_addr = bus.ic_read_addr;
            mdl_last = OWN_IC;
         end
         if (cyc < 80) dq.push_back(w);
         else if (cyc < 160) tq.push_back(w);
      end
   endtask

   initial begin
      int exp_dir [4];
      int exp_tie [4];
      exp_dir = '{OWN_IC, OWN_WR, OWN_DC, OWN_IC};
`ifdef ARB_ROUND_ROBIN_EN
      exp_tie = '{OWN_DC, OWN_IC, OWN_DC, OWN_IC};
`else
      exp_tie = '{OWN_DC, OWN_DC, OWN_DC, OWN_DC};
`endif
      reset       = 1'b0;
      rel_cyc     = 3;
      quiet_until = 4;
      rst_done    = 1'b0;
      m_acked     = 1'b0;
      m_cnt       = 0;
      m_lat       = 0;
      t5_acks     = 0;
      wr_data     = '0;
      for (int k = 0; k < 3; k++) begin
         req[k]   = 1'b0;
         outst[k] = 1'b0;
         raddr[k] = '0;
      end
      bus.mem_ack     = 1'b0;
      bus.mem_data_in = '0;
      apply_inputs();
      mdl_busy      = 1'b0;
      mdl_own       = OWN_DC;
      mdl_g         = 0;
      mdl_rw        = 1'b0;
      mdl_addr      = '0;
      mdl_wdata     = '0;
      mdl_ack_cyc   = -1;
      mdl_ack_own   = OWN_DC;
      mdl_samp_from = 0;
      mdl_last      = OWN_DC;
      mdl_fresh     = 1'b1;
      exp_ic        = '0;
      exp_dc        = '0;

      for (cyc = 0; cyc < NCYC; cyc++) begin
         @(posedge clk);
         #1;
         drive_step();
         @(negedge clk);
         model_step();
      end

      chk("dir_grant_count", dq.size(), 4);
      for (int i = 0; i < 4; i++)
         if (i < dq.size()) chk("dir_grant_order", dq[i], exp_dir[i]);
      chk("tie_grant_count_ge4", tq.size() >= 4, 1'b1);
      for (int i = 0; i < 4; i++)
         if (i < tq.size()) chk("tie_grant_order", tq[i], exp_tie[i]);
      chk("t5_single_ack", t5_acks, 1);
      chk("mid_tx_reset_applied", rst_done, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
